// File: rtl/sram_frame_arbiter.sv
// Frame-buffer SRAM arbiter: shares one single-port SRAM between a pixel
// writer (capture side, only during blanking) and a pixel reader (display
// side). Reads have priority, with a starvation limit that forces a bus
// turnaround so a pending write is eventually granted.
module sram_frame_arbiter #(
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 480,
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 20,
    parameter int COORD_W      = 10,
    parameter int READ_LAT     = 1,
    parameter int STARVE_MAX   = 8
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic               iWR_Valid,
    input  logic [COORD_W-1:0] iWR_X,
    input  logic [COORD_W-1:0] iWR_Y,
    input  logic [DATA_W-1:0]  iWR_Data,
    output logic               oWR_Ready,
    input  logic               iWR_Enable,
    input  logic               iRD_Valid,
    input  logic [COORD_W-1:0] iRD_X,
    input  logic [COORD_W-1:0] iRD_Y,
    output logic               oRD_Ready,
    output logic [DATA_W-1:0]  oRD_Data,
    output logic               oRD_Valid,
    output logic [ADDR_W-1:0]  oSRAM_ADDR,
    output logic               oSRAM_WE_N,
    output logic               oSRAM_OE_N,
    inout  wire  [DATA_W-1:0]  ioSRAM_DQ,
    output logic [15:0]        oDropCount,
    output logic               oBusy
);

    localparam int          SW    = $clog2(STARVE_MAX + 1);
    localparam logic [31:0] FW_U  = 32'(FRAME_WIDTH);
    localparam logic [31:0] FH_U  = 32'(FRAME_HEIGHT);

    logic [SW-1:0]       starve_cnt;
    logic                starved;
    logic [READ_LAT-1:0] pipe_v;       // read in flight, one bit per latency stage
    logic [READ_LAT-1:0] pipe_ok;      // matching in-range flag
    logic                rd_in_flight;
    logic                wr_pending;
    logic                wr_eligible;
    logic                wr_fire;
    logic                rd_fire;
    logic                wr_in_range;
    logic                rd_in_range;
    logic [ADDR_W-1:0]   wr_addr;
    logic [ADDR_W-1:0]   rd_addr;
    logic [63:0]         wr_addr_full;
    logic [63:0]         rd_addr_full;
    logic                dq_oe;
    logic [DATA_W-1:0]   dq_out;

    // Linear pixel addresses and frame-bounds tests for both requesters.
    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        wr_addr_full = '0;
        rd_addr_full = '0;
        wr_addr_full = 64'(iWR_Y) * 64'(FW_U) + 64'(iWR_X);
        rd_addr_full = 64'(iRD_Y) * 64'(FW_U) + 64'(iRD_X);
        wr_addr      = ADDR_W'(wr_addr_full);
        rd_addr      = ADDR_W'(rd_addr_full);
        wr_in_range  = (32'(iWR_X) < FW_U) && (32'(iWR_Y) < FH_U);
        rd_in_range  = (32'(iRD_X) < FW_U) && (32'(iRD_Y) < FH_U);
    end

    assign rd_in_flight = |pipe_v;
    assign starved      = (starve_cnt == SW'(STARVE_MAX));
    assign wr_pending   = iWR_Valid & iWR_Enable;
    assign wr_eligible  = wr_pending & ~rd_in_flight;

    // Reads win unless the writer has been starved; then reads are held off
    // until the pipeline drains and the write takes the bus.
    assign oRD_Ready = iRST & iRD_Valid & ~(starved & wr_pending);
    assign oWR_Ready = iRST & wr_eligible & (~iRD_Valid | starved);
    assign rd_fire   = iRD_Valid & oRD_Ready;
    assign wr_fire   = iWR_Valid & oWR_Ready;

    assign oBusy     = rd_in_flight;
    assign ioSRAM_DQ = dq_oe ? dq_out : 'z;

    // Starvation counter: counts reads granted over a waiting write.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            starve_cnt <= '0;
        end else if (wr_fire || !wr_pending) begin
            starve_cnt <= '0;
        end else if (rd_fire && !starved) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // SRAM command register: one-cycle WE_N/OE_N strobes, address holds when idle.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            oSRAM_ADDR <= '0;
            oSRAM_WE_N <= 1'b1;
            oSRAM_OE_N <= 1'b1;
            dq_oe      <= 1'b0;
            dq_out     <= '0;
        end else begin
            oSRAM_WE_N <= 1'b1;
            oSRAM_OE_N <= 1'b1;
            dq_oe      <= 1'b0;
            if (wr_fire && wr_in_range) begin
                oSRAM_ADDR <= wr_addr;
                oSRAM_WE_N <= 1'b0;
                dq_oe      <= 1'b1;
                dq_out     <= iWR_Data;
            end else if (rd_fire && rd_in_range) then_read: begin
                oSRAM_ADDR <= rd_addr;
                oSRAM_OE_N <= 1'b0;
            end
        end
    end

    // Read latency pipeline; out-of-range reads travel it too so their
    // zero data returns at the same latency as a real read.
    // NOTE: the pipeline is reset explicitly so reads in flight at reset can never emerge afterwards.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            pipe_v  <= '0;
            pipe_ok <= '0;
        end else begin
            pipe_v[0]  <= rd_fire;
            pipe_ok[0] <= rd_in_range;
            for (int i = 1; i < READ_LAT; i++) begin
                pipe_v[i]  <= pipe_v[i-1];
                pipe_ok[i] <= pipe_ok[i-1];
            end
        end
    end

    // Data capture at the end of the latency window, strobed for one cycle.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            oRD_Valid <= 1'b0;
            oRD_Data  <= '0;
        end else begin
            oRD_Valid <= pipe_v[READ_LAT-1];
            if (pipe_v[READ_LAT-1]) begin
                oRD_Data <= pipe_ok[READ_LAT-1] ? ioSRAM_DQ : '0;
            end
        end
    end

    // Saturating count of out-of-range requests accepted.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            oDropCount <= '0;
        end else if (((wr_fire && !wr_in_range) || (rd_fire && !rd_in_range)) &&
                     (oDropCount != 16'hFFFF)) begin
            oDropCount <= oDropCount + 16'd1;
        end
    end

endmodule
